// File: rtl/out_drain_ctrl.sv
`default_nettype none
// ============================================================================
// out_drain_ctrl : ping-pong accumulator snapshot and serial drain to dst buffer
// Option OUT_RELU_EN clamps negative drained words to zero.   Rev 1.0
// ============================================================================
module out_drain_ctrl #(
  parameter int F_NUM = 16,
  parameter int DW    = 32,
  parameter int OAW   = 12,
  parameter int PSW   = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      s_init,
  input  logic                      k_fin,
  input  logic [$clog2(F_NUM)-1:0]  od,
  input  logic [PSW-1:0]            os,
  input  logic [F_NUM*DW-1:0]       sum,
  output logic                      out_busy,
  output logic                      outr,
  input  logic                      out_ready,
  output logic [OAW-1:0]            oa,
  output logic [DW-1:0]             x,
  output logic                      sample_done,
  output logic                      err_ovf
);

  localparam int CW  = $clog2(F_NUM);
  localparam int PW  = CW + PSW + 1;
  localparam int AFW = (PW > OAW) ? PW : OAW;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [F_NUM*DW-1:0] bank_q [2];
  logic [F_NUM*DW-1:0] bank_d [2];
  logic [1:0]          full_q, full_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [CW-1:0]       od_q, od_d;
  logic [PSW-1:0]      pos_q, pos_d;
  logic                err_q, err_d;

  logic                clr;
  logic                accept;
  logic                last_ch;
  logic                last_pos;
  logic                release_bank;
  logic                free_bank;
  logic                capture;
  logic [DW-1:0]       word;
  logic [DW-1:0]       x_word;
  logic [AFW-1:0]      addr_full;

  assign clr          = !run || s_init;
  assign accept       = (state_q == ST_DRAIN) && out_ready;
  assign last_ch      = (ch_q == od_q);
  assign last_pos     = (pos_q == (os - PSW'(1)));
  assign release_bank = accept && last_ch;
  // A bank released this cycle is already free for a coincident capture.
  assign free_bank    = !full_q[wr_q] || (release_bank && (rd_q == wr_q));
  assign capture      = k_fin && !clr && free_bank;

  assign word      = bank_q[rd_q][ch_q*DW +: DW];
  assign addr_full = AFW'(ch_q) * AFW'(os) + AFW'(pos_q);

`ifdef OUT_RELU_EN
  assign x_word = word[DW-1] ? '0 : word;
`else
  assign x_word = word;
`endif

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    full_d  = full_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ch_d    = ch_q;
    od_d    = od_q;
    pos_d   = pos_q;
    err_d   = err_q;

    if (clr) begin
      state_d = ST_IDLE;
      full_d  = '0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      ch_d    = '0;
      pos_d   = '0;
    end else begin
      if (k_fin && !free_bank) begin
        err_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (full_q[rd_q]) begin
            state_d = ST_DRAIN;
            od_d    = od;
            ch_d    = '0;
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            if (last_ch) begin
              full_d[rd_q] = 1'b0;
              rd_d         = !rd_q;
              ch_d         = '0;
              pos_d        = last_pos ? '0 : pos_q + PSW'(1);
              if (full_q[!rd_q]) begin
                od_d = od;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Capture after release so a freed bank can be refilled in the same edge.
      if (capture) begin
        bank_d[wr_q] = sum;
        full_d[wr_q] = 1'b1;
        wr_d         = !wr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ch_q      <= '0;
      od_q      <= '0;
      pos_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ch_q      <= ch_d;
      od_q      <= od_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
    end
  end

  assign out_busy    = full_q[0] && full_q[1];
  assign outr        = (state_q == ST_DRAIN);
  assign oa          = outr ? addr_full[OAW-1:0] : '0;
  assign x           = outr ? x_word : '0;
  assign sample_done = release_bank && last_pos;
  assign err_ovf     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_out_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_out_drain_ctrl : directed + randomized bench with a snapshot-queue model
// Rev 1.0
// ============================================================================
module tb_out_drain_ctrl;

  localparam int F_NUM = 16;
  localparam int DW    = 32;
  localparam int OAW   = 12;
  localparam int PSW   = 10;
  localparam int CW    = 4;

  logic                clk = 1'b0;
  logic                rst_n, run, s_init, k_fin, out_ready;
  logic [CW-1:0]       od;
  logic [PSW-1:0]      os;
  logic [F_NUM*DW-1:0] sum;
  logic                out_busy, outr, sample_done, err_ovf;
  logic [OAW-1:0]      oa;
  logic [DW-1:0]       x;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  out_drain_ctrl #(.F_NUM(F_NUM), .DW(DW), .OAW(OAW), .PSW(PSW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .s_init(s_init), .k_fin(k_fin),
    .od(od), .os(os), .sum(sum), .out_busy(out_busy), .outr(outr),
    .out_ready(out_ready), .oa(oa), .x(x), .sample_done(sample_done),
    .err_ovf(err_ovf)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of captured snapshots, drained word by word.
  logic [F_NUM*DW-1:0] snap_q[$];
  int   m_ch, m_pos, n_acc;
  logic m_err, prev_stall;

  function automatic logic [DW-1:0] exp_word(input logic [F_NUM*DW-1:0] s, input int c);
    logic [DW-1:0] v;
    v = s[c*DW +: DW];
`ifdef OUT_RELU_EN
    if ($signed(v) < 0) v = '0;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    logic acc, last, exp_sd;
    if (rst_n !== 1'b1) begin
      snap_q.delete();
      m_ch = 0; m_pos = 0; m_err = 1'b0; prev_stall = 1'b0;
    end else begin
      check_val("out_busy", 64'(out_busy), 64'(snap_q.size() == 2));
      check_val("err_ovf", 64'(err_ovf), 64'(m_err));
      if (prev_stall) check_val("hold_outr", 64'(outr), 64'(1));
      acc = 1'b0; last = 1'b0;
      if (outr) begin
        if (snap_q.size() == 0) begin
          check_val("spurious_outr", 64'(outr), 64'(0));
        end else begin
          check_val("oa", 64'(oa), 64'((m_ch * int'(os) + m_pos) % (1 << OAW)));
          check_val("x", 64'(x), 64'(exp_word(snap_q[0], m_ch)));
          acc  = out_ready;
          last = (m_ch == int'(od));
        end
      end
      exp_sd = acc && last && (m_pos == int'(os) - 1);
      check_val("sample_done", 64'(sample_done), 64'(exp_sd));
      if (!run || s_init) begin
        snap_q.delete();
        m_ch = 0; m_pos = 0; prev_stall = 1'b0;
      end else begin
        if (acc) begin
          n_acc++;
          if (last) begin
            void'(snap_q.pop_front());
            m_ch  = 0;
            m_pos = (m_pos == int'(os) - 1) ? 0 : m_pos + 1;
          end else begin
            m_ch++;
          end
        end
        if (k_fin) begin
          if (snap_q.size() < 2) snap_q.push_back(sum);
          else m_err = 1'b1;
        end
        prev_stall = outr && !out_ready;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_sum;
    for (int i = 0; i < F_NUM; i++) sum[i*DW +: DW] = $urandom;
  endtask

  task automatic new_cfg(input int new_od, input int new_os);
    k_fin  = 1'b0;
    s_init = 1'b1;
    tick;
    s_init = 1'b0;
    od     = CW'(new_od);
    os     = PSW'(new_os);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    k_fin = 1'b0;
    while ((snap_q.size() != 0 || outr) && n < 500) begin
      tick;
      n++;
    end
    check_val(tag, 64'(snap_q.size()), 64'(0));
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ones, n, acc0;
    rst_n = 1'b0; run = 1'b0; s_init = 1'b0; k_fin = 1'b0; out_ready = 1'b0;
    od = '0; os = PSW'(1); sum = '0;
    repeat (3) tick;
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    check_val("rst_outr", 64'(outr), 64'(0));
    check_val("rst_oa", 64'(oa), 64'(0));
    check_val("rst_x", 64'(x), 64'(0));
    check_val("rst_busy", 64'(out_busy), 64'(0));
    check_val("rst_sd", 64'(sample_done), 64'(0));
    check_val("rst_err", 64'(err_ovf), 64'(0));
    tick;

    // Basic drain with latency check
    new_cfg(3, 2);
    out_ready = 1'b1;
    for (int i = 0; i < F_NUM; i++) sum[i*DW +: DW] = DW'(i + 10);
    k_fin = 1'b1; tick; k_fin = 1'b0;
    @(negedge clk);
    check_val("lat_t1_outr", 64'(outr), 64'(0));
    tick; @(negedge clk);
    check_val("lat_t2_outr", 64'(outr), 64'(1));
    check_val("lat_t2_oa", 64'(oa), 64'(0));
    check_val("lat_t2_x", 64'(x), 64'(10));
    wait_drain("basic1_drain");
    k_fin = 1'b1; tick; k_fin = 1'b0;
    wait_drain("basic2_drain");

    // Back-to-back captures, overflow and gap-free drain
    new_cfg(15, 4);
    out_ready = 1'b1;
    rand_sum; k_fin = 1'b1; tick;
    rand_sum; tick;
    rand_sum;
    @(negedge clk);
    check_val("busy_before_3rd", 64'(out_busy), 64'(1));
    tick; k_fin = 1'b0;
    @(negedge clk);
    check_val("err_after_3rd", 64'(err_ovf), 64'(1));
    ones = 0;
    for (int i = 0; i < 31; i++) begin
      if (outr) ones++;
      tick; @(negedge clk);
    end
    check_val("no_bubble", 64'(ones), 64'(31));
    check_val("drain_end", 64'(outr), 64'(0));
    wait_drain("b2b_drain");
    do_reset;

    // Backpressure pattern 1,0,0,1
    new_cfg(3, 2);
    rand_sum; k_fin = 1'b1; tick; k_fin = 1'b0;
    n = 0;
    while ((snap_q.size() != 0 || outr) && n < 200) begin
      out_ready = (n % 4 == 0) || (n % 4 == 3);
      tick; n++;
    end
    check_val("bp_drain", 64'(snap_q.size()), 64'(0));
    out_ready = 1'b1;

    // Capture coincident with final accept of the only full bank
    new_cfg(3, 2);
    acc0 = n_acc;
    rand_sum; k_fin = 1'b1; tick; k_fin = 1'b0;
    repeat (4) tick;
    rand_sum; k_fin = 1'b1; tick; k_fin = 1'b0;
    @(negedge clk);
    check_val("bnd_err", 64'(err_ovf), 64'(0));
    wait_drain("bnd_drain");
    check_val("bnd_words", 64'(n_acc - acc0), 64'(8));

    // Address wrap
    new_cfg(15, 1023);
    rand_sum; k_fin = 1'b1; tick; rand_sum; tick; k_fin = 1'b0;
    wait_drain("wrap_drain");

    // s_init abort while stalled, then restart from address 0
    new_cfg(15, 8);
    out_ready = 1'b0;
    rand_sum; k_fin = 1'b1; tick; k_fin = 1'b0;
    repeat (4) tick;
    s_init = 1'b1; tick; s_init = 1'b0;
    @(negedge clk);
    check_val("abort_outr", 64'(outr), 64'(0));
    out_ready = 1'b1;
    rand_sum; k_fin = 1'b1; tick; k_fin = 1'b0;
    n = 0;
    while (!outr && n < 10) begin tick; n++; end
    @(negedge clk);
    check_val("abort_oa0", 64'(oa), 64'(0));
    wait_drain("abort_drain");

    // run=0 mid-drain
    rand_sum; k_fin = 1'b1; tick; k_fin = 1'b0;
    repeat (5) tick;
    run = 1'b0; tick; run = 1'b1;
    @(negedge clk);
    check_val("run0_outr", 64'(outr), 64'(0));
    check_val("run0_busy", 64'(out_busy), 64'(0));

    // Reset mid-drain
    new_cfg(15, 3);
    rand_sum; k_fin = 1'b1; tick; k_fin = 1'b0;
    repeat (5) tick;
    do_reset;
    @(negedge clk);
    check_val("mrst_outr", 64'(outr), 64'(0));
    check_val("mrst_oa", 64'(oa), 64'(0));
    check_val("mrst_x", 64'(x), 64'(0));
    check_val("mrst_sd", 64'(sample_done), 64'(0));
    check_val("mrst_busy", 64'(out_busy), 64'(0));

    // Negative word handling
    new_cfg(1, 2);
    sum = '0;
    sum[0*DW +: DW] = -32'sd5;
    sum[1*DW +: DW] = 32'sd7;
    k_fin = 1'b1; tick; k_fin = 1'b0;
    tick; @(negedge clk);
`ifdef OUT_RELU_EN
    check_val("relu_x0", 64'(x), 64'(0));
`else
    check_val("relu_x0", 64'(x), 64'(32'hFFFF_FFFB));
`endif
    tick; @(negedge clk);
    check_val("relu_x1", 64'(x), 64'(7));
    wait_drain("relu_drain");

    // Randomized episodes
    for (int ep = 0; ep < 8; ep++) begin
      new_cfg($urandom_range(0, F_NUM - 1),
              (ep % 2 == 0) ? $urandom_range(1, 4) : $urandom_range(1, 1023));
      for (int c = 0; c < 150; c++) begin
        rand_sum;
        k_fin     = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        tick;
      end
      out_ready = 1'b1;
      wait_drain("rand_drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
